// File: rtl/name_table_arbiter_pkg.sv
// Shared name-table geometry, CPU write entry layout and lane-to-byte mapping
// used by the name table arbiter and its write FIFO.
package name_table_arbiter_pkg;
  localparam int NT_WORDS      = 240;
  localparam int NT_TILES      = 960;
  localparam int NT_ADDR_BIT   = 8;
  localparam int TILE_ADDR_BIT = 10;
  localparam int TILE_BIT      = 8;

  typedef struct packed {
    logic [TILE_ADDR_BIT-1:0] addr;
    logic [TILE_BIT-1:0]      data;
  } wr_entry_t;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  // Lane 0 is the most significant byte of the RAM word.
  function automatic logic [3:0] lane_we(input logic [1:0] lane);
    return 4'b1000 >> lane;
  endfunction
endpackage

// File: rtl/name_table_arbiter_nt_wr_fifo.sv
// Small synchronous FIFO buffering CPU tile writes until the RAM is free.
module nt_wr_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 18,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [W-1:0]     dout,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);
  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    level_d = level_q + LVL_W'(push) - LVL_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: the level gates every read.
  always_ff @(posedge clk) mem_q <= mem_d;

  assign dout  = mem_q[rd_ptr_q];
  assign level = level_q;
  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
endmodule

// File: rtl/name_table_arbiter.sv
// Shares the background name table RAM between the renderer (read), buffered
// CPU tile writes and a bulk-clear engine; renderer always has priority.
module name_table_arbiter
  import name_table_arbiter_pkg::*;
#(
  parameter  int FIFO_DEPTH = 4,
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     vgaActive,
  input  logic [NT_ADDR_BIT-1:0]   renderAddr,
  input  logic                     cpuWrValid,
  output logic                     cpuWrReady,
  input  logic [TILE_ADDR_BIT-1:0] cpuWrTileAddr,
  input  logic [TILE_BIT-1:0]      cpuWrTileData,
  input  logic                     clearStart,
  input  logic [TILE_BIT-1:0]      clearTile,
  output logic                     clearBusy,
  output logic                     clearDone,
  output logic                     errRange,
  input  logic                     errClr,
  output logic [LVL_W-1:0]         fifoLevel,
  output logic [NT_ADDR_BIT-1:0]   ramAddr,
  output logic [3:0]               ramWe,
  output logic [31:0]              ramWrData
);
  state_e                 state_q, state_d;
  logic [NT_ADDR_BIT-1:0] cnt_q, cnt_d;
  logic [TILE_BIT-1:0]    tile_q, tile_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic                     fifo_full, fifo_empty, push, pop, accept, in_range;
  logic [$bits(wr_entry_t)-1:0] fifo_dout;
  wr_entry_t                head;

  assign accept   = cpuWrValid && !fifo_full;
  assign in_range = cpuWrTileAddr < TILE_ADDR_BIT'(NT_TILES);
  assign push     = accept && in_range;
  // The FIFO only drains when neither the renderer nor a clear holds the RAM.
  assign pop      = !vgaActive && (state_q == ST_IDLE) && !fifo_empty;
  assign head     = wr_entry_t'(fifo_dout);

  nt_wr_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(wr_entry_t))) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  ({cpuWrTileAddr, cpuWrTileData}),
    .pop  (pop),
    .dout (fifo_dout),
    .level(fifoLevel),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tile_d  = tile_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: if (clearStart) begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
        tile_d  = clearTile;
      end
      ST_CLEAR: if (!vgaActive) begin
        cnt_d = cnt_q + NT_ADDR_BIT'(1);
        if (cnt_q == NT_ADDR_BIT'(NT_WORDS - 1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A new range error wins over a same-cycle clear request.
    if (accept && !in_range) err_d = 1'b1;
    else if (errClr)         err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tile_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tile_q  <= tile_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    ramAddr   = '0;
    ramWe     = 4'h0;
    ramWrData = '0;
    if (vgaActive) begin
      ramAddr = renderAddr;
    end else if (state_q == ST_CLEAR) begin
      ramAddr   = cnt_q;
      ramWe     = 4'hF;
      ramWrData = {4{tile_q}};
    end else if (!fifo_empty) begin
      ramAddr   = head.addr[TILE_ADDR_BIT-1:2];
      ramWe     = lane_we(head.addr[1:0]);
      ramWrData = {4{head.data}};
    end
  end

  assign cpuWrReady = !fifo_full;
  assign clearBusy  = (state_q == ST_CLEAR);
  assign clearDone  = done_q;
  assign errRange   = err_q;
endmodule

// File: tb/tb_name_table_arbiter.sv
// Directed and randomized checks of the name table arbiter against a queue
// and tile-array reference model.
module tb_name_table_arbiter;
  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vgaActive = 1'b0;
  logic [7:0]  renderAddr = '0;
  logic        cpuWrValid = 1'b0;
  logic        cpuWrReady;
  logic [9:0]  cpuWrTileAddr = '0;
  logic [7:0]  cpuWrTileData = '0;
  logic        clearStart = 1'b0;
  logic [7:0]  clearTile = '0;
  logic        clearBusy, clearDone, errRange;
  logic        errClr = 1'b0;
  logic [2:0]  fifoLevel;
  logic [7:0]  ramAddr;
  logic [3:0]  ramWe;
  logic [31:0] ramWrData;

  name_table_arbiter #(.FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .vgaActive(vgaActive), .renderAddr(renderAddr),
    .cpuWrValid(cpuWrValid), .cpuWrReady(cpuWrReady),
    .cpuWrTileAddr(cpuWrTileAddr), .cpuWrTileData(cpuWrTileData),
    .clearStart(clearStart), .clearTile(clearTile), .clearBusy(clearBusy),
    .clearDone(clearDone), .errRange(errRange), .errClr(errClr),
    .fifoLevel(fifoLevel), .ramAddr(ramAddr), .ramWe(ramWe), .ramWrData(ramWrData)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] a;
    logic [7:0] d;
  } ent_t;

  ent_t       q[$];
  logic [7:0] model[960];
  logic [7:0] ram_img[960];
  logic       exp_err = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         ea, busy_cyc, nmis;
  logic       done_seen, found;
  logic [9:0] wa[5];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-cycle scoreboard: expectations from the priority rules, then model update.
  task automatic sb();
    ent_t e;
    chk("level", 64'(fifoLevel), 64'(q.size()));
    chk("ready", 64'(cpuWrReady), 64'(q.size() < FD));
    chk("err", 64'(errRange), 64'(exp_err));
    if (vgaActive) begin
      chk("vga_we", 64'(ramWe), 64'h0);
      chk("vga_addr", 64'(ramAddr), 64'(renderAddr));
    end else if (clearBusy) begin
      chk("clr_we", 64'(ramWe), 64'hF);
    end else if (q.size() > 0) begin
      e = q[0];
      chk("drain", {20'h0, ramAddr, ramWe, ramWrData},
          {20'h0, e.a[9:2], 4'(4'b1000 >> e.a[1:0]), {4{e.d}}});
    end else begin
      chk("idle", {20'h0, ramAddr, ramWe, ramWrData}, 64'h0);
    end
    for (int l = 0; l < 4; l++)
      if (ramWe[3-l] && ramAddr < 8'd240) ram_img[int'(ramAddr)*4+l] = ramWrData[(3-l)*8 +: 8];
    if (rst) begin
      q.delete();
      exp_err = 1'b0;
    end else begin
      if (!vgaActive && !clearBusy && q.size() > 0) void'(q.pop_front());
      if (cpuWrValid && cpuWrReady && cpuWrTileAddr >= 10'd960) exp_err = 1'b1;
      else if (errClr) exp_err = 1'b0;
      if (cpuWrValid && cpuWrReady && cpuWrTileAddr < 10'd960) begin
        q.push_back('{cpuWrTileAddr, cpuWrTileData});
        model[cpuWrTileAddr] = cpuWrTileData;
      end
    end
  endtask

  task automatic look(); #1; endtask
  task automatic adv(); sb(); @(posedge clk); #1; endtask
  task automatic cyc(); look(); adv(); endtask

  initial begin
    foreach (model[i]) begin model[i] = 8'h00; ram_img[i] = 8'h00; end
    // Reset state
    vgaActive = 1'b1; renderAddr = 8'h33;
    @(posedge clk); #1; look();
    chk("rst_busy", 64'(clearBusy), 0); chk("rst_done", 64'(clearDone), 0);
    chk("rst_err", 64'(errRange), 0);   chk("rst_level", 64'(fifoLevel), 0);
    chk("rst_ready", 64'(cpuWrReady), 1); chk("rst_we", 64'(ramWe), 0);
    chk("rst_vga_addr", 64'(ramAddr), 64'h33); chk("rst_data", 64'(ramWrData), 0);
    vgaActive = 1'b0; look();
    chk("rst_addr", 64'(ramAddr), 0);
    adv(); rst = 1'b0;

    // Single write, drained the next cycle
    cpuWrValid = 1'b1; cpuWrTileAddr = 10'd5; cpuWrTileData = 8'h3C; look();
    chk("w1_we_same", 64'(ramWe), 0);
    adv(); cpuWrValid = 1'b0; look();
    chk("w1", {ramAddr, ramWe, ramWrData}, {8'd1, 4'b0100, 32'h3C3C3C3C});
    adv(); look();
    chk("w1_level", 64'(fifoLevel), 0); chk("w1_we_after", 64'(ramWe), 0);
    adv();

    // Renderer holds the RAM while the FIFO fills, then four writes in order
    vgaActive = 1'b1; renderAddr = 8'h7F;
    for (int k = 0; k < 5; k++) begin
      wa[k] = 10'(k * 37 + 2);
      cpuWrValid = 1'b1; cpuWrTileAddr = wa[k]; cpuWrTileData = 8'(8'h10 + k); look();
      chk("fill_ready", 64'(cpuWrReady), 64'(k < 4));
      chk("fill_addr", 64'(ramAddr), 64'h7F);
      adv();
    end
    cpuWrValid = 1'b0; look();
    chk("fill_level", 64'(fifoLevel), 4);
    adv(); vgaActive = 1'b0;
    for (int k = 0; k < 4; k++) begin
      look();
      chk("drain_order", {ramAddr, ramWe, ramWrData},
          {wa[k][9:2], 4'(4'b1000 >> wa[k][1:0]), {4{8'(8'h10 + k)}}});
      adv();
    end
    cyc();

    // Full clear with no renderer traffic
    clearStart = 1'b1; clearTile = 8'h20; look();
    chk("clr_start_idle", 64'(ramWe), 0);
    adv(); clearStart = 1'b0;
    foreach (model[i]) model[i] = 8'h20;
    for (int i = 0; i < 240; i++) begin
      look();
      if (i == 0 || i == 239 || i == 120) begin
        chk("clr_busy", 64'(clearBusy), 1);
        chk("clr_word", {ramAddr, ramWe, ramWrData}, {8'(i), 4'hF, 32'h20202020});
        chk("clr_nodone", 64'(clearDone), 0);
      end else if (ramAddr != 8'(i)) chk("clr_seq", 64'(ramAddr), 64'(i));
      adv();
    end
    look();
    chk("clr_done", 64'(clearDone), 1); chk("clr_idle", 64'(clearBusy), 0);
    adv(); look();
    chk("clr_done_pulse", 64'(clearDone), 0);
    adv();

    // Clear stalled 10 cycles by the renderer; a second start is ignored
    clearStart = 1'b1; clearTile = 8'h55; look(); adv(); clearStart = 1'b0;
    foreach (model[i]) model[i] = 8'h55;
    ea = 0; busy_cyc = 0; done_seen = 1'b0;
    for (int c = 0; c < 400 && !done_seen; c++) begin
      vgaActive = (c >= 100 && c < 110); renderAddr = 8'(c);
      clearStart = (c == 50); clearTile = (c == 50) ? 8'hAA : 8'h55;
      look();
      if (clearDone) begin
        done_seen = 1'b1;
        chk("clr2_len", 64'(busy_cyc), 250);
      end else begin
        if (clearBusy) busy_cyc++;
        if (!vgaActive && clearBusy) begin
          if (ramAddr != 8'(ea) || ramWrData != 32'h55555555)
            chk("clr2_word", {ramAddr, ramWrData}, {8'(ea), 32'h55555555});
          ea++;
        end
      end
      adv();
    end
    clearStart = 1'b0; vgaActive = 1'b0;
    chk("clr2_done", 64'(done_seen), 1); chk("clr2_words", 64'(ea), 240);

    // Out-of-range writes and the sticky error flag
    cpuWrValid = 1'b1; cpuWrTileAddr = 10'd963; cpuWrTileData = 8'h11; look();
    chk("bad_ready", 64'(cpuWrReady), 1);
    adv(); cpuWrValid = 1'b0; look();
    chk("bad_err", 64'(errRange), 1); chk("bad_we", 64'(ramWe), 0);
    chk("bad_level", 64'(fifoLevel), 0);
    adv();
    cpuWrValid = 1'b1; cpuWrTileAddr = 10'd1000; errClr = 1'b1; cyc();
    cpuWrValid = 1'b0; errClr = 1'b0; look();
    chk("err_set_wins", 64'(errRange), 1);
    adv(); errClr = 1'b1; cyc(); errClr = 1'b0; look();
    chk("err_clr", 64'(errRange), 0);
    adv();

    // Randomized traffic against the scoreboard and tile model
    for (int c = 0; c < 600; c++) begin
      vgaActive     = ($urandom_range(0, 9) < 4);
      renderAddr    = 8'($urandom_range(0, 239));
      cpuWrValid    = $urandom_range(0, 1) == 1;
      cpuWrTileAddr = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(960, 1023))
                                                  : 10'($urandom_range(0, 959));
      cpuWrTileData = 8'($urandom);
      errClr        = ($urandom_range(0, 19) == 0);
      cyc();
    end
    vgaActive = 1'b0; cpuWrValid = 1'b0; errClr = 1'b0;
    for (int c = 0; c < 8; c++) cyc();
    look();
    chk("rand_drained", 64'(fifoLevel), 0);
    nmis = 0;
    foreach (model[i]) if (ram_img[i] !== model[i]) nmis++;
    chk("rand_ram_image", 64'(nmis), 0);
    adv();

    // Reset in the middle of a clear with two writes pending
    clearStart = 1'b1; clearTile = 8'h77; look(); adv(); clearStart = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      cpuWrValid = (c == 1 || c == 2); cpuWrTileAddr = 10'(c * 10); cpuWrTileData = 8'(c);
      look();
      if (clearBusy && ramAddr == 8'd100) begin
        found = 1'b1;
        chk("mid_level", 64'(fifoLevel), 2);
        rst = 1'b1;
      end
      adv();
    end
    cpuWrValid = 1'b0; rst = 1'b0;
    chk("mid_found", 64'(found), 1);
    look();
    chk("mid_busy", 64'(clearBusy), 0); chk("mid_level0", 64'(fifoLevel), 0);
    chk("mid_we", 64'(ramWe), 0);       chk("mid_nodone", 64'(clearDone), 0);
    adv(); look();
    chk("mid_nodone2", 64'(clearDone), 0); chk("mid_we2", 64'(ramWe), 0);
    adv();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
